// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: access sizes and FSM states.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/grant/response port.
//   master (MEM stage): REQ, WE, ADR, WDATA, BE out; GNT, RVALID, RDATA in
//   slave  (cache)    : the reverse
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  MCACHE_REQ_SM;
  logic                  MCACHE_WE_SM;
  logic [ADDR_W-1:0]     MCACHE_ADR_SM;
  logic [DATA_W-1:0]     MCACHE_WDATA_SM;
  logic [DATA_W/8-1:0]   MCACHE_BE_SM;
  logic                  MCACHE_GNT_SC;
  logic                  MCACHE_RVALID_SC;
  logic [DATA_W-1:0]     MCACHE_RDATA_SC;

  modport master (
    output MCACHE_REQ_SM, MCACHE_WE_SM, MCACHE_ADR_SM, MCACHE_WDATA_SM, MCACHE_BE_SM,
    input  MCACHE_GNT_SC, MCACHE_RVALID_SC, MCACHE_RDATA_SC
  );

  modport slave (
    input  MCACHE_REQ_SM, MCACHE_WE_SM, MCACHE_ADR_SM, MCACHE_WDATA_SM, MCACHE_BE_SM,
    output MCACHE_GNT_SC, MCACHE_RVALID_SC, MCACHE_RDATA_SC
  );
endinterface

// File: rtl/mem_stage_align.sv
// Combinational lane logic shared by loads and stores.
//   off_i/size_i/sign_i : byte offset, access size, sign-extend for loads
//   st_data_i -> st_wdata_o, st_be_o : lane-replicated store data and enables
//   ld_word_i -> ld_data_o           : extracted and extended load data
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_size_t   size_i,
  input  logic        sign_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (off_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    st_wdata_o = st_data_i;
    st_be_o    = 4'b1111;
    ld_data_o  = ld_word_i;
    case (size_i)
      BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << off_i;
        ld_data_o  = {{24{sign_i & ld_byte[7]}}, ld_byte};
      end
      HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        ld_data_o  = {{16{sign_i & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: pops EXE->MEM FIFO entries, performs loads/stores on the data
// cache port and holds each result in a single-entry MEM->WBK register that
// also serves as the MEM bypass source.
//   clk, reset_n            : clock, async active-low reset
//   EXE2MEM_*, *_RE         : EXE FIFO head and pop
//   mcache                  : cache request/grant/response port (master)
//   MEM2WBK_*, *_RM         : output register, empty flag and WBK pop
//
// state     | meaning
// IDLE      | serving the FIFO head; loads/stores request here
// WAIT_RESP | load granted, waiting for RVALID
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              EXE2MEM_EMPTY_SE,
  output logic              EXE2MEM_POP_SM,
  input  logic [DATA_W-1:0] RES_RE,
  input  logic [DATA_W-1:0] MEM_DATA_RE,
  input  logic [5:0]        DEST_RE,
  input  logic [1:0]        MEM_SIZE_RE,
  input  logic              MEM_SIGN_EXTEND_RE,
  input  logic              MEM_LOAD_RE,
  input  logic              MEM_STORE_RE,
  input  logic              WB_RE,
  input  logic              EXCEPTION_RE,
  input  logic              CSR_WENABLE_RE,
  input  logic [DATA_W-1:0] CSR_RDATA_RE,
  input  logic              MULT_INST_RE,
  mem_stage_if.master       mcache,
  input  logic              MEM2WBK_POP_SW,
  output logic              MEM2WBK_EMPTY_SM,
  output logic [DATA_W-1:0] MEM_RES_RM,
  output logic [5:0]        MEM_DEST_RM,
  output logic              WB_RM,
  output logic              CSR_WENABLE_RM,
  output logic              MULT_INST_RM,
  output logic              EXCEPTION_RM,
  output logic [DATA_W-1:0] CSR_RDATA_RM
);
  mem_state_t  state_q, state_d;
  logic [1:0]  off_q, off_d;
  mem_size_t   size_q, size_d;
  logic        sign_q, sign_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] res_q, csr_rdata_q;
  logic [5:0]        dest_q;
  logic              wb_q, csr_we_q, mult_q, exc_q;

  logic              head_valid, slot_free, req, we, push, pop;
  logic [DATA_W-1:0] push_res;

  logic [1:0]  a_off;
  mem_size_t   a_size;
  logic        a_sign;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;

  assign head_valid = !EXE2MEM_EMPTY_SE;
  assign slot_free  = !out_valid_q || MEM2WBK_POP_SW;

  // Load extraction uses the access parameters captured at grant.
  assign a_off  = (state_q == WAIT_RESP) ? off_q  : RES_RE[1:0];
  assign a_size = (state_q == WAIT_RESP) ? size_q : mem_size_t'(MEM_SIZE_RE);
  assign a_sign = (state_q == WAIT_RESP) ? sign_q : MEM_SIGN_EXTEND_RE;

  mem_stage_align u_align (
    .off_i      (a_off),
    .size_i     (a_size),
    .sign_i     (a_sign),
    .st_data_i  (MEM_DATA_RE),
    .ld_word_i  (mcache.MCACHE_RDATA_SC),
    .st_wdata_o (st_wdata),
    .st_be_o    (st_be),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    size_d   = size_q;
    sign_d   = sign_q;
    req      = 1'b0;
    we       = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    push_res = RES_RE;
    case (state_q)
      IDLE: begin
        if (head_valid) begin
          if (!MEM_LOAD_RE && !MEM_STORE_RE) begin
            if (slot_free) begin
              push = 1'b1;
              pop  = 1'b1;
            end
          end else if (MEM_STORE_RE) begin
            if (slot_free) begin
              req = 1'b1;
              we  = 1'b1;
              if (mcache.MCACHE_GNT_SC) begin
                push = 1'b1;
                pop  = 1'b1;
              end
            end
          end else if (!out_valid_q) begin
            // Loads need a truly empty slot: the register must stay empty
            // until the response arrives.
            req = 1'b1;
            if (mcache.MCACHE_GNT_SC) begin
              off_d   = RES_RE[1:0];
              size_d  = mem_size_t'(MEM_SIZE_RE);
              sign_d  = MEM_SIGN_EXTEND_RE;
              state_d = WAIT_RESP;
            end
          end
        end
      end
      WAIT_RESP: begin
        if (mcache.MCACHE_RVALID_SC) begin
          push     = 1'b1;
          pop      = 1'b1;
          push_res = ld_data;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (push)                out_valid_d = 1'b1;
    else if (MEM2WBK_POP_SW) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= WORD;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      dest_q      <= '0;
      wb_q        <= 1'b0;
      csr_we_q    <= 1'b0;
      mult_q      <= 1'b0;
      exc_q       <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      if (push) begin
        res_q       <= push_res;
        dest_q      <= DEST_RE;
        wb_q        <= WB_RE;
        csr_we_q    <= CSR_WENABLE_RE;
        mult_q      <= MULT_INST_RE;
        exc_q       <= EXCEPTION_RE;
        csr_rdata_q <= CSR_RDATA_RE;
      end
    end
  end

  assign EXE2MEM_POP_SM         = pop;
  assign mcache.MCACHE_REQ_SM   = req;
  assign mcache.MCACHE_WE_SM    = we;
  assign mcache.MCACHE_ADR_SM   = req ? {RES_RE[ADDR_W-1:2], 2'b00} : '0;
  assign mcache.MCACHE_WDATA_SM = we ? st_wdata : '0;
  assign mcache.MCACHE_BE_SM    = req ? st_be : '0;

  assign MEM2WBK_EMPTY_SM = !out_valid_q;
  assign MEM_RES_RM       = res_q;
  assign MEM_DEST_RM      = out_valid_q ? dest_q : '0;
  assign WB_RM            = wb_q;
  assign CSR_WENABLE_RM   = csr_we_q;
  assign MULT_INST_RM     = mult_q;
  assign EXCEPTION_RM     = exc_q;
  assign CSR_RDATA_RM     = csr_rdata_q;
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk, reset_n;
  logic        EXE2MEM_EMPTY_SE, EXE2MEM_POP_SM;
  logic [31:0] RES_RE, MEM_DATA_RE, CSR_RDATA_RE;
  logic [5:0]  DEST_RE;
  logic [1:0]  MEM_SIZE_RE;
  logic        MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, WB_RE;
  logic        EXCEPTION_RE, CSR_WENABLE_RE, MULT_INST_RE;
  logic        MEM2WBK_POP_SW, MEM2WBK_EMPTY_SM;
  logic [31:0] MEM_RES_RM, CSR_RDATA_RM;
  logic [5:0]  MEM_DEST_RM;
  logic        WB_RM, CSR_WENABLE_RM, MULT_INST_RM, EXCEPTION_RM;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) mc ();

  mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .EXE2MEM_EMPTY_SE(EXE2MEM_EMPTY_SE), .EXE2MEM_POP_SM(EXE2MEM_POP_SM),
    .RES_RE(RES_RE), .MEM_DATA_RE(MEM_DATA_RE), .DEST_RE(DEST_RE),
    .MEM_SIZE_RE(MEM_SIZE_RE), .MEM_SIGN_EXTEND_RE(MEM_SIGN_EXTEND_RE),
    .MEM_LOAD_RE(MEM_LOAD_RE), .MEM_STORE_RE(MEM_STORE_RE), .WB_RE(WB_RE),
    .EXCEPTION_RE(EXCEPTION_RE), .CSR_WENABLE_RE(CSR_WENABLE_RE),
    .CSR_RDATA_RE(CSR_RDATA_RE), .MULT_INST_RE(MULT_INST_RE),
    .mcache(mc),
    .MEM2WBK_POP_SW(MEM2WBK_POP_SW), .MEM2WBK_EMPTY_SM(MEM2WBK_EMPTY_SM),
    .MEM_RES_RM(MEM_RES_RM), .MEM_DEST_RM(MEM_DEST_RM), .WB_RM(WB_RM),
    .CSR_WENABLE_RM(CSR_WENABLE_RM), .MULT_INST_RM(MULT_INST_RM),
    .EXCEPTION_RM(EXCEPTION_RM), .CSR_RDATA_RM(CSR_RDATA_RM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [5:0]  dest;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    v = w >> {27'b0, off, 3'b000};
    case (sz)
      2'b10: begin
        v = v & 32'h0000_00FF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = v & 32'h0000_FFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] off, input logic [1:0] sz);
    case (sz)
      2'b10:   return 4'b0001 << off;
      2'b01:   return (off >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_model(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b10:   return {24'b0, d[7:0]} * 32'h0101_0101;
      2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // WBK side: whenever a valid result is consumed, it must be the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && !MEM2WBK_EMPTY_SM && MEM2WBK_POP_SW) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_res", MEM_RES_RM, e.res);
        chk("sb_dest", 32'(MEM_DEST_RM), 32'(e.dest));
        chk("sb_wb", 32'(WB_RM), 32'd1);
      end
    end
  end

  task automatic set_head(input logic [31:0] res, input logic [31:0] data, input logic [5:0] dest,
                          input logic [1:0] sz, input logic sg, input logic ld, input logic st);
    RES_RE = res; MEM_DATA_RE = data; DEST_RE = dest; MEM_SIZE_RE = sz;
    MEM_SIGN_EXTEND_RE = sg; MEM_LOAD_RE = ld; MEM_STORE_RE = st; WB_RE = 1'b1;
    EXCEPTION_RE = 1'b0; CSR_WENABLE_RE = 1'b0; MULT_INST_RE = 1'b0; CSR_RDATA_RE = 32'h0;
    EXE2MEM_EMPTY_SE = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic [31:0] res, input logic [5:0] dest);
    exp_t e;
    e.res = res; e.dest = dest;
    sb.push_back(e);
    set_head(res, 32'h0, dest, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("alu_pop", 32'(EXE2MEM_POP_SM), 32'd1);
    chk("alu_req", 32'(mc.MCACHE_REQ_SM), 32'd0);
    tick();
    EXE2MEM_EMPTY_SE = 1'b1;
    chk("alu_lat", 32'(MEM2WBK_EMPTY_SM), 32'd0);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] rdata, input logic [5:0] dest, input int gd, input int rd);
    exp_t e;
    e.res = ld_model(rdata, addr[1:0], sz, sg); e.dest = dest;
    sb.push_back(e);
    set_head(addr, 32'h0, dest, sz, sg, 1'b1, 1'b0);
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("ld_req_wait", 32'(mc.MCACHE_REQ_SM), 32'd1);
      chk("ld_adr_wait", mc.MCACHE_ADR_SM, {addr[31:2], 2'b00});
      chk("ld_pop_wait", 32'(EXE2MEM_POP_SM), 32'd0);
      tick();
    end
    mc.MCACHE_GNT_SC = 1'b1;
    @(negedge clk);
    chk("ld_req", 32'(mc.MCACHE_REQ_SM), 32'd1);
    chk("ld_we", 32'(mc.MCACHE_WE_SM), 32'd0);
    chk("ld_adr", mc.MCACHE_ADR_SM, {addr[31:2], 2'b00});
    chk("ld_pop_gnt", 32'(EXE2MEM_POP_SM), 32'd0);
    tick();
    mc.MCACHE_GNT_SC = 1'b0;
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("ld_req_resp", 32'(mc.MCACHE_REQ_SM), 32'd0);
      chk("ld_pop_early", 32'(EXE2MEM_POP_SM), 32'd0);
      tick();
    end
    mc.MCACHE_RVALID_SC = 1'b1;
    mc.MCACHE_RDATA_SC  = rdata;
    @(negedge clk);
    chk("ld_pop", 32'(EXE2MEM_POP_SM), 32'd1);
    tick();
    mc.MCACHE_RVALID_SC = 1'b0;
    mc.MCACHE_RDATA_SC  = 32'h0;
    EXE2MEM_EMPTY_SE    = 1'b1;
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz,
                           input logic [5:0] dest, input int gd);
    exp_t e;
    logic [3:0]  be;
    logic [31:0] wd;
    be = be_model(addr[1:0], sz);
    wd = wd_model(data, sz);
    e.res = addr; e.dest = dest;
    sb.push_back(e);
    set_head(addr, data, dest, sz, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= gd; i++) begin
      if (i == gd) mc.MCACHE_GNT_SC = 1'b1;
      @(negedge clk);
      chk("st_req", 32'(mc.MCACHE_REQ_SM), 32'd1);
      chk("st_we", 32'(mc.MCACHE_WE_SM), 32'd1);
      chk("st_adr", mc.MCACHE_ADR_SM, {addr[31:2], 2'b00});
      chk("st_be", 32'(mc.MCACHE_BE_SM), 32'(be));
      chk("st_wdata", mc.MCACHE_WDATA_SM, wd);
      chk("st_pop", 32'(EXE2MEM_POP_SM), (i == gd) ? 32'd1 : 32'd0);
      tick();
    end
    mc.MCACHE_GNT_SC = 1'b0;
    EXE2MEM_EMPTY_SE = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    EXE2MEM_EMPTY_SE = 1'b1;
    RES_RE = 0; MEM_DATA_RE = 0; DEST_RE = 0; MEM_SIZE_RE = 0; MEM_SIGN_EXTEND_RE = 0;
    MEM_LOAD_RE = 0; MEM_STORE_RE = 0; WB_RE = 0; EXCEPTION_RE = 0; CSR_WENABLE_RE = 0;
    CSR_RDATA_RE = 0; MULT_INST_RE = 0; MEM2WBK_POP_SW = 0;
    mc.MCACHE_GNT_SC = 0; mc.MCACHE_RVALID_SC = 0; mc.MCACHE_RDATA_SC = 0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);
    chk("rst_res", MEM_RES_RM, 32'd0);
    chk("rst_dest", 32'(MEM_DEST_RM), 32'd0);
    chk("rst_req", 32'(mc.MCACHE_REQ_SM), 32'd0);
    chk("rst_pop", 32'(EXE2MEM_POP_SM), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // ALU pass-through, latency 1, one-cycle pop, held until WBK pops
    run_alu(32'h1234, 6'd5);
    chk("alu_res", MEM_RES_RM, 32'h1234);
    chk("alu_dest", 32'(MEM_DEST_RM), 32'd5);
    @(negedge clk);
    chk("alu_pop_once", 32'(EXE2MEM_POP_SM), 32'd0);
    tick();
    MEM2WBK_POP_SW = 1'b1;
    tick();
    chk("wbk_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);
    chk("wbk_dest0", 32'(MEM_DEST_RM), 32'd0);

    // signed byte load, GNT at once, RVALID two cycles after the request
    run_load(32'h0000_1003, 2'b10, 1'b1, 32'h80FF_FF00, 6'd7, 0, 1);
    // byte store with GNT held off for three cycles
    run_store(32'h0000_0001, 32'h0000_00AB, 2'b10, 6'd8, 3);
    tick();

    // load stalls while the output register is full
    MEM2WBK_POP_SW = 1'b0;
    run_alu(32'h0000_0055, 6'd3);
    set_head(32'h0000_2002, 32'h0, 6'd9, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_noreq", 32'(mc.MCACHE_REQ_SM), 32'd0);
      chk("full_nopop", 32'(EXE2MEM_POP_SM), 32'd0);
      tick();
    end
    MEM2WBK_POP_SW = 1'b1;
    @(negedge clk);
    chk("full_popcycle_noreq", 32'(mc.MCACHE_REQ_SM), 32'd0);
    tick();
    run_load(32'h0000_2002, 2'b01, 1'b0, 32'hBEEF_1234, 6'd9, 0, 1);
    tick();

    // reset while waiting for a load response
    set_head(32'h0000_3000, 32'h0, 6'd4, 2'b00, 1'b0, 1'b1, 1'b0);
    mc.MCACHE_GNT_SC = 1'b1;
    @(negedge clk);
    chk("rw_req", 32'(mc.MCACHE_REQ_SM), 32'd1);
    tick();
    mc.MCACHE_GNT_SC = 1'b0;
    @(negedge clk);
    chk("rw_wait_noreq", 32'(mc.MCACHE_REQ_SM), 32'd0);
    #1;
    EXE2MEM_EMPTY_SE = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rw_empty", 32'(MEM2WBK_EMPTY_SM), 32'd1);
    chk("rw_req_off", 32'(mc.MCACHE_REQ_SM), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    mc.MCACHE_RVALID_SC = 1'b1;
    mc.MCACHE_RDATA_SC  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rw_late_nopop", 32'(EXE2MEM_POP_SM), 32'd0);
    tick();
    mc.MCACHE_RVALID_SC = 1'b0;
    chk("rw_late_nopush", 32'(MEM2WBK_EMPTY_SM), 32'd1);
    run_alu(32'h0000_0777, 6'd11);
    tick();

    // mixed traffic
    for (int n = 0; n < 12; n++) begin
      int          kind;
      logic [1:0]  sz, off;
      logic [31:0] a, d;
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 2));
      off  = (sz == 2'b10) ? 2'($urandom_range(0, 3)) :
             (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      a    = {$urandom(), 2'b00} | {30'b0, off};
      d    = $urandom();
      if (kind == 0)      run_alu(d, 6'($urandom_range(1, 63)));
      else if (kind == 1) run_load(a, sz, 1'($urandom_range(0, 1)), d, 6'($urandom_range(1, 63)),
                                   $urandom_range(0, 3), $urandom_range(0, 2));
      else                run_store(a, d, sz, 6'($urandom_range(1, 63)), $urandom_range(0, 3));
      tick();
    end

    repeat (3) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
